// File: rtl/acc_sched.sv
// acc_sched: round-robin scheduler sharing one start/finish accelerator with timeout and stray-finish counting.
module acc_sched #(
  parameter int NUM_REQ        = 4,
  parameter int ID_W           = 2,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int TIMER_W        = 16
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [NUM_REQ-1:0] req_i,
  output logic [NUM_REQ-1:0] done_o,
  output logic [NUM_REQ-1:0] err_o,
  output logic               busy_o,
  output logic [ID_W-1:0]    grant_id_o,
  output logic               acc_start_o,
  input  logic               acc_finish_i,
  output logic [7:0]         stray_cnt_o
);
  typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;
  state_t state_q, state_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d, grant_q, grant_d, pick, idx;
  logic [ID_W:0] sum;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [NUM_REQ-1:0] done_q, done_d, err_q, err_d;
  logic start_q, start_d, busy_q, busy_d, timeout;
  logic [7:0] stray_q, stray_d;
  // Scan downward so the last hit is the nearest set bit at or above rr_ptr.
  always_comb begin
    pick = rr_ptr_q;
    sum = '0;
    idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      sum = {1'b0, rr_ptr_q} + (ID_W+1)'(i);
      idx = sum >= (ID_W+1)'(NUM_REQ) ? ID_W'(sum - (ID_W+1)'(NUM_REQ)) : ID_W'(sum);
      if (req_i[idx]) pick = idx;
    end
  end
  assign timeout = timer_q == TIMER_W'(TIMEOUT_CYCLES - 1);
  always_comb begin
    state_d = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d = grant_q;
    timer_d = timer_q;
    done_d = '0;
    err_d = '0;
    start_d = 1'b0;
    case (state_q)
      IDLE: if (|req_i) begin
        grant_d = pick;
        start_d = 1'b1;
        state_d = START;
      end
      START: begin
        timer_d = '0;
        state_d = WAIT;
      end
      WAIT: if (acc_finish_i || timeout) begin
        done_d[grant_q] = acc_finish_i;
        err_d[grant_q] = !acc_finish_i;
        state_d = DONE;
      end else begin
        timer_d = timer_q + 1'b1;
      end
      DONE: begin
        rr_ptr_d = grant_q == ID_W'(NUM_REQ - 1) ? '0 : grant_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
    stray_d = (acc_finish_i && state_q != WAIT && stray_q != 8'hff) ? stray_q + 1'b1 : stray_q;
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      rr_ptr_q <= '0;
      grant_q <= '0;
      timer_q <= '0;
      done_q <= '0;
      err_q <= '0;
      start_q <= 1'b0;
      busy_q <= 1'b0;
      stray_q <= '0;
    end else begin
      state_q <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q <= grant_d;
      timer_q <= timer_d;
      done_q <= done_d;
      err_q <= err_d;
      start_q <= start_d;
      busy_q <= busy_d;
      stray_q <= stray_d;
    end
  end
  assign done_o = done_q;
  assign err_o = err_q;
  assign busy_o = busy_q;
  assign grant_id_o = grant_q;
  assign acc_start_o = start_q;
  assign stray_cnt_o = stray_q;
endmodule

// File: tb/tb_acc_sched.sv
// tb_acc_sched: directed scoreboard bench; dut0 uses the default timeout, dut1 a 10-cycle timeout.
module tb_acc_sched;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;
  logic [3:0] req[2];
  logic fin[2];
  logic [3:0] done[2], err[2];
  logic busy[2], st[2];
  logic [1:0] gid[2];
  logic [7:0] stray[2];
  acc_sched #(.NUM_REQ(4), .ID_W(2), .TIMEOUT_CYCLES(1000), .TIMER_W(16)) dut0 (
    .clk_i(clk), .reset_i(reset), .req_i(req[0]), .done_o(done[0]), .err_o(err[0]),
    .busy_o(busy[0]), .grant_id_o(gid[0]), .acc_start_o(st[0]), .acc_finish_i(fin[0]),
    .stray_cnt_o(stray[0]));
  acc_sched #(.NUM_REQ(4), .ID_W(2), .TIMEOUT_CYCLES(10), .TIMER_W(16)) dut1 (
    .clk_i(clk), .reset_i(reset), .req_i(req[1]), .done_o(done[1]), .err_o(err[1]),
    .busy_o(busy[1]), .grant_id_o(gid[1]), .acc_start_o(st[1]), .acc_finish_i(fin[1]),
    .stray_cnt_o(stray[1]));
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int total = 0, bad = 0;
  typedef struct {int d; int c; logic [3:0] a; logic [3:0] b;} ev_t;
  ev_t qs[$], qr[$];
  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at cycle %0d", n, act, exp, cyc);
    end
  endtask
  task automatic wait_to(int c);
    while (cyc < c) @(negedge clk);
  endtask
  task automatic chk_reset_vals(int d);
    chk("rst_done", done[d], 0);
    chk("rst_err", err[d], 0);
    chk("rst_busy", busy[d], 0);
    chk("rst_gid", gid[d], 0);
    chk("rst_start", st[d], 0);
    chk("rst_stray", stray[d], 0);
  endtask
  // lat < 0 means the accelerator never answers and a timeout is expected.
  task automatic run_job(int d, logic [3:0] rv, int lat, int id);
    int s, r, to;
    to = d ? 10 : 1000;
    req[d] = rv;
    s = cyc + 1;
    r = lat >= 0 ? s + lat + 1 : s + to + 1;
    qs.push_back('{d, s, 4'(id), 4'b0});
    qr.push_back('{d, r, lat >= 0 ? 4'(1 << id) : 4'b0, lat >= 0 ? 4'b0 : 4'(1 << id)});
    wait_to(s);
    chk("busy_run", busy[d], 1);
    if (lat >= 0) begin
      wait_to(s + lat);
      fin[d] = 1'b1;
      @(negedge clk);
      fin[d] = 1'b0;
    end
    wait_to(r);
    chk("busy_done", busy[d], 1);
    wait_to(r + 1);
    chk("busy_idle", busy[d], 0);
  endtask
  always @(negedge clk) begin
    ev_t e;
    for (int d = 0; d < 2; d++) begin
      if (st[d]) begin
        if (qs.size() == 0) begin
          total++;
          bad++;
          $display("FAIL start_unexp: dut%0d got grant %0d want no start at cycle %0d", d, gid[d], cyc);
        end else begin
          e = qs.pop_front();
          chk("start_dut", d, e.d);
          chk("start_cyc", cyc, e.c);
          chk("start_id", gid[d], e.a);
        end
      end
      if (|{done[d], err[d]}) begin
        if (qr.size() == 0) begin
          total++;
          bad++;
          $display("FAIL resp_unexp: dut%0d got done=%b err=%b want none at cycle %0d", d, done[d], err[d], cyc);
        end else begin
          e = qr.pop_front();
          chk("resp_dut", d, e.d);
          chk("resp_cyc", cyc, e.c);
          chk("resp_done", done[d], e.a);
          chk("resp_err", err[d], e.b);
        end
      end
    end
  end
  initial begin
    #300000;
    $display("FAIL watchdog: got timeout want test end");
    $fatal(1);
  end
  initial begin
    int c0;
    reset = 1'b1;
    req = '{4'b0, 4'b0};
    fin = '{1'b0, 1'b0};
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk_reset_vals(0);
    chk_reset_vals(1);
    @(negedge clk);
    run_job(0, 4'b0010, 100, 1);
    run_job(0, 4'b1011, 4, 3);
    req[0] = 4'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    run_job(0, 4'b1111, 4, 0);
    run_job(0, 4'b1111, 4, 1);
    run_job(0, 4'b1111, 4, 2);
    run_job(0, 4'b1111, 4, 3);
    run_job(0, 4'b1111, 4, 0);
    req[0] = 4'b0;
    @(negedge clk);
    c0 = cyc;
    req[0] = 4'b0100;
    qs.push_back('{0, c0 + 1, 4'd2, 4'b0});
    wait_to(c0 + 4);
    reset = 1'b1;
    req[0] = 4'b0;
    @(negedge clk);
    reset = 1'b0;
    fin[0] = 1'b1;
    chk_reset_vals(0);
    @(negedge clk);
    fin[0] = 1'b0;
    chk("abort_stray", stray[0], 1);
    chk("abort_busy", busy[0], 0);
    run_job(0, 4'b1001, 4, 0);
    run_job(0, 4'b1000, 4, 3);
    req[0] = 4'b0;
    for (int i = 0; i < 300; i++) begin
      fin[0] = 1'b1;
      @(negedge clk);
      fin[0] = 1'b0;
      @(negedge clk);
      if (i == 98) chk("stray_mid", stray[0], 100);
    end
    chk("stray_sat", stray[0], 255);
    chk("stray_busy", busy[0], 0);
    run_job(1, 4'b0001, -1, 0);
    run_job(1, 4'b0001, 3, 0);
    run_job(1, 4'b0001, 10, 0);
    run_job(1, 4'b0001, 9, 0);
    req[1] = 4'b0;
    repeat (5) @(negedge clk);
    chk("qs_left", qs.size(), 0);
    chk("qr_left", qr.size(), 0);
    chk("dut1_stray", stray[1], 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
